// File: rtl/meter_scheduler.sv
// meter_scheduler: round-robin scheduler that shares one duration meter across NCH pulse inputs.
// Define METER_SCHED_TIMEOUT_EN to build the stuck-channel timeout counter.
module meter_scheduler #(
  parameter int NCH            = 4,
  parameter int SETTLE_EDGES   = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [NCH-1:0]           ch_mask,
  input  logic [NCH-1:0]           ch_in,
  output logic                     meter_d,
  output logic                     meter_clear,
  input  logic [31:0]              meter_q,
  input  logic [31:0]              meter_duty,
  output logic                     res_valid,
  input  logic                     res_ack,
  output logic [$clog2(NCH)-1:0]   res_ch,
  output logic [31:0]              res_period,
  output logic [31:0]              res_duty,
  output logic                     res_timeout,
  output logic                     busy,
  output logic [2:0]               state_dbg
);
  localparam int CW = $clog2(NCH);

  typedef enum logic [2:0] {
    S_IDLE, S_SELECT, S_CLEAR, S_SETTLE, S_CAPTURE, S_HOLD
  } state_t;

  state_t         state;
  logic [NCH-1:0] sync1, sync2, sync3;
  logic [CW-1:0]  cur_ch;
  logic           clear_q;
  logic           clr_cnt;
  logic [7:0]     edge_cnt;
  logic           sel_edge;

`ifdef METER_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;
  logic          timed_out;
`else
  logic          res_timeout_unused_cfg;
  assign res_timeout_unused_cfg = ^TIMEOUT_CYCLES;
  assign res_timeout = 1'b0;
`endif

  // Next enabled channel after 'last', wrapping NCH-1 -> 0; lowest offset wins.
  function automatic logic [CW-1:0] next_ch(input logic [CW-1:0] last,
                                            input logic [NCH-1:0] mask);
    int idx;
    next_ch = last;
    for (int k = NCH; k >= 1; k--) begin
      idx = (int'(last) + k) % NCH;
      if (mask[idx]) next_ch = idx[CW-1:0];
    end
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= ch_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign meter_d     = sync2[cur_ch];
  assign sel_edge    = sync2[cur_ch] & ~sync3[cur_ch];
  // Reset drives the clear immediately; otherwise only the CLEAR state raises it.
  assign meter_clear = clear_q | reset;
  assign busy        = (state != S_IDLE);
  assign state_dbg   = state;

  // Result handshake: res_valid rises with res_* stable and stays high until a
  // cycle with res_ack=1; the transfer happens on that clock edge. res_ack is
  // ignored whenever res_valid is low.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      clear_q    <= 1'b0;
      clr_cnt    <= 1'b0;
      cur_ch     <= CW'(NCH - 1);
      edge_cnt   <= '0;
      res_valid  <= 1'b0;
      res_ch     <= '0;
      res_period <= '0;
      res_duty   <= '0;
`ifdef METER_SCHED_TIMEOUT_EN
      to_cnt      <= '0;
      timed_out   <= 1'b0;
      res_timeout <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (enable && ch_mask != '0) state <= S_SELECT;
        end
        S_SELECT: begin
          if (!enable || ch_mask == '0) begin
            state <= S_IDLE;
          end else begin
            cur_ch  <= next_ch(cur_ch, ch_mask);
            clear_q <= 1'b1;
            clr_cnt <= 1'b0;
            state   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          edge_cnt <= '0;
`ifdef METER_SCHED_TIMEOUT_EN
          to_cnt    <= '0;
          timed_out <= 1'b0;
`endif
          if (!enable) begin
            clear_q <= 1'b0;
            state   <= S_IDLE;
          end else if (clr_cnt) begin
            clear_q <= 1'b0;
            state   <= S_SETTLE;
          end else begin
            clr_cnt <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (!enable) begin
            state <= S_IDLE;
          end else if (sel_edge) begin
            // An edge always wins over a timeout landing in the same cycle.
            edge_cnt <= edge_cnt + 8'd1;
`ifdef METER_SCHED_TIMEOUT_EN
            to_cnt <= '0;
`endif
            if (edge_cnt == 8'(SETTLE_EDGES - 1)) state <= S_CAPTURE;
          end
`ifdef METER_SCHED_TIMEOUT_EN
          else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timed_out <= 1'b1;
            state     <= S_CAPTURE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        S_CAPTURE: begin
          if (!enable) begin
            state <= S_IDLE;
          end else begin
            res_ch <= cur_ch;
`ifdef METER_SCHED_TIMEOUT_EN
            res_timeout <= timed_out;
            res_period  <= timed_out ? 32'd0 : meter_q;
            res_duty    <= timed_out ? 32'd0 : meter_duty;
`else
            res_period  <= meter_q;
            res_duty    <= meter_duty;
`endif
            res_valid <= 1'b1;
            state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (res_ack) begin
            res_valid <= 1'b0;
            state     <= enable ? S_SELECT : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_meter_scheduler.sv
// Randomized bench for meter_scheduler: round-robin channel model, meter model and result scoreboard.
module tb_meter_scheduler;
  localparam int NCH            = 4;
  localparam int SETTLE_EDGES   = 4;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int CW             = $clog2(NCH);
  localparam int W              = CW + 65;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           enable = 1'b0;
  logic [NCH-1:0] ch_mask = '0;
  logic [NCH-1:0] ch_in = '0;
  logic           meter_d, meter_clear;
  logic [31:0]    meter_q = '0, meter_duty = '0;
  logic           res_valid;
  logic           res_ack = 1'b0;
  logic [CW-1:0]  res_ch;
  logic [31:0]    res_period, res_duty;
  logic           res_timeout, busy;
  logic [2:0]     state_dbg;

  meter_scheduler #(
    .NCH(NCH), .SETTLE_EDGES(SETTLE_EDGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .enable(enable), .ch_mask(ch_mask), .ch_in(ch_in),
    .meter_d(meter_d), .meter_clear(meter_clear), .meter_q(meter_q), .meter_duty(meter_duty),
    .res_valid(res_valid), .res_ack(res_ack), .res_ch(res_ch), .res_period(res_period),
    .res_duty(res_duty), .res_timeout(res_timeout), .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: actual=no finish required=finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int             errors = 0, checks = 0;
  logic [W-1:0]   exp_q[$];
  int             per[NCH];
  int             ph[NCH];
  int             model_last = NCH - 1;
  int             cur_exp_ch = 0;
  int             results_seen = 0;
  int             settle_cycles = 0, edge_seen = 0, clr_len = 0;
  bit             in_settle = 0, prev_clear = 0, prev_valid = 0, hold_mode = 0;
  logic [NCH-1:0] h0 = '0, h1 = '0, h2 = '0;
  logic [W-1:0]   snap;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int rr_next(input int last, input logic [NCH-1:0] m);
    for (int k = 1; k <= NCH; k++)
      if (m[(last + k) % NCH]) return (last + k) % NCH;
    return last;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_meter_clear"}, meter_clear, 1);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_fields"}, {res_ch, res_period, res_duty, res_timeout}, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_meter_d"}, meter_d, 0);
  endtask

  // ---------------- channel drivers (free-running square waves) ----------------
  always @(posedge clock) begin
    #2;
    for (int i = 0; i < NCH; i++) begin
      if (per[i] == 0) ch_in[i] = 1'b0;
      else begin
        ph[i] = (ph[i] + 1) % per[i];
        ch_in[i] = (ph[i] < per[i] / 2);
      end
    end
  end

  // ---------------- result acceptor ----------------
  int hold_cnt = 0, ack_target = 0;
  initial begin
    forever begin
      @(negedge clock); #1;
      if (res_valid) begin
        res_ack = (hold_cnt >= ack_target);
        hold_cnt++;
      end else begin
        hold_cnt   = 0;
        ack_target = hold_mode ? 50 : $urandom_range(0, 4);
        res_ack    = ($urandom_range(0, 7) == 0);
      end
    end
  end

  // ---------------- monitor + meter model ----------------
  logic [31:0]  mq, md;
  logic [W-1:0] e;
  bit           exp_to;
  always @(negedge clock) begin
    if (reset) begin
      h2 = '0; h1 = '0; h0 = ch_in;
      prev_clear = 0; prev_valid = 0; clr_len = 0; in_settle = 0;
      model_last = NCH - 1;
      exp_q.delete();
    end else begin
      if (meter_clear && !prev_clear) begin
        cur_exp_ch = rr_next(model_last, ch_mask);
        model_last = cur_exp_ch;
      end
      if (meter_clear) clr_len++;
      if (!meter_clear && prev_clear) begin
        check("clear_len", clr_len, 2);
        clr_len = 0;
        mq = $urandom; md = $urandom;
        meter_q = mq; meter_duty = md;
        exp_to = (per[cur_exp_ch] == 0);
        if (exp_to) exp_q.push_back({CW'(cur_exp_ch), 64'd0, 1'b1});
        else        exp_q.push_back({CW'(cur_exp_ch), mq, md, 1'b0});
        in_settle = 1; settle_cycles = 0; edge_seen = 0;
      end
      if (in_settle) begin
        check("meter_d", meter_d, h1[cur_exp_ch]);
        settle_cycles++;
        if (h1[cur_exp_ch] && !h2[cur_exp_ch]) edge_seen++;
      end
      if (res_valid && !prev_valid) begin
        results_seen++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL result_unexpected: actual=ch %0d required=no result", res_ch);
        end else begin
          e = exp_q.pop_front();
          check("res_ch", res_ch, e[W-1 -: CW]);
          check("res_period", res_period, e[64:33]);
          check("res_duty", res_duty, e[32:1]);
          check("res_timeout", res_timeout, e[0]);
          if (e[0])
            check("timeout_latency", (settle_cycles >= TIMEOUT_CYCLES && settle_cycles <= TIMEOUT_CYCLES + 4), 1);
          else
            check("settle_edges", edge_seen, SETTLE_EDGES);
        end
        in_settle = 0;
        snap = {res_ch, res_period, res_duty, res_timeout};
        meter_q = $urandom; meter_duty = $urandom;
      end else if (res_valid && prev_valid) begin
        check("hold_stable", {res_ch, res_period, res_duty, res_timeout}, snap);
        check("hold_no_clear", meter_clear, 0);
      end
      if (!busy) in_settle = 0;
      h2 = h1; h1 = h0; h0 = ch_in;
      prev_clear = meter_clear; prev_valid = res_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_phase(input logic [NCH-1:0] mask, input int n);
    int target, cyc;
    @(negedge clock); #1;
    ch_mask = mask; enable = 1'b1;
    target = results_seen + n;
    cyc = 0;
    while (results_seen < target && cyc < 20000) begin @(negedge clock); #1; cyc++; end
    check("phase_results", results_seen >= target, 1);
    enable = 1'b0;
    cyc = 0;
    while (busy && cyc < 200) begin @(negedge clock); #1; cyc++; end
    check("phase_idle", busy, 0);
    check("phase_drain", exp_q.size(), 0);
  endtask

  task automatic randomize_periods();
    for (int i = 0; i < NCH; i++) per[i] = 8 + 2 * $urandom_range(0, 16);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    randomize_periods();
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    #1 reset = 1'b0;
    #1 check("clear_after_reset", meter_clear, 0);

    // Empty mask keeps the scheduler idle.
    @(negedge clock); #1; ch_mask = '0; enable = 1'b1;
    repeat (5) @(negedge clock);
    check("idle_mask0", busy, 0);
    #1 enable = 1'b0;

    run_phase(4'b1011, 6);
    run_phase(4'b0101, 2);

    hold_mode = 1;
    run_phase(4'b0110, 1);
    hold_mode = 0;

    // Abort while settling, then resume at the following channel.
    @(negedge clock); #1; ch_mask = 4'b1111; enable = 1'b1;
    cyc = 0;
    while (!(in_settle && settle_cycles >= 3) && cyc < 500) begin @(negedge clock); #1; cyc++; end
    check("abort_reach_settle", in_settle, 1);
    enable = 1'b0;
    @(negedge clock);
    check("abort_busy", busy, 0);
    check("abort_no_result", res_valid, 0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    repeat (3) @(negedge clock);
    check("abort_stays_idle", {busy, res_valid}, 0);
    run_phase(4'b1111, 3);

    repeat (6) begin
      randomize_periods();
      run_phase(NCH'($urandom_range(1, 15)), $urandom_range(1, 5));
    end

`ifdef METER_SCHED_TIMEOUT_EN
    per[2] = 0;
    run_phase(4'b0100, 1);
    per[2] = 12;
    run_phase(4'b0110, 2);
`endif

    // Asynchronous reset in the middle of CLEAR.
    @(negedge clock); #1; ch_mask = 4'b0011; enable = 1'b1;
    cyc = 0;
    while (!meter_clear && cyc < 100) begin @(negedge clock); cyc++; end
    check("reach_clear", meter_clear, 1);
    @(posedge clock); #3;
    reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(negedge clock);
    #1 enable = 1'b0; reset = 1'b0;
    #1 check("clear_after_reset2", meter_clear, 0);
    run_phase(4'b0011, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
